puf_scan_master: RTL and testbench

- Host-side controller for the PUF macro's serial challenge/response interface.
- Takes a parallel challenge plus PUF select/length configuration from the host.
- Shifts the challenge into the macro's `si` pin, then pulses the macro's evaluation `reset`.
- Shifts the response back in from `so` and presents it as a parallel word with a valid/ready handshake.
- Sits between the host register interface and the `puf_super` macro, and drives every macro input except `clk` and `rstn`.

---
 rtl/puf_scan_master.sv | 154 +++++++++++++++
 tb/tb_puf_scan_master.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/puf_scan_master.sv
// Host-side controller for the PUF macro serial interface: shifts a challenge
// out on si, pulses the evaluation reset, then shifts the response back in.
module puf_scan_master #(
  parameter int CHAL_W      = 16,
  parameter int RESP_W      = 16,
  parameter int EVAL_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [CHAL_W-1:0] chal,
  input  logic [1:0]        sel_in,
  input  logic [1:0]        len_in,
  output logic              busy,
  output logic [RESP_W-1:0] resp,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              si,
  input  logic              so,
  output logic              puf_reset,
  output logic [1:0]        puf_sel,
  output logic [1:0]        length
);

  localparam int MAX_AB = (CHAL_W > RESP_W) ? CHAL_W : RESP_W;
  localparam int MAX_V  = (MAX_AB > EVAL_CYCLES) ? MAX_AB : EVAL_CYCLES;
  localparam int CNT_W  = $clog2(MAX_V + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EVAL,
    CAPTURE,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CHAL_W-1:0]   chal_sr_q, chal_sr_d;
  logic [RESP_W-1:0]   resp_sr_q, resp_sr_d;
  logic [RESP_W-1:0]   resp_q, resp_d;
  logic                valid_q, valid_d;
  logic                si_q, si_d;
  logic                puf_reset_q, puf_reset_d;
  logic [1:0]          sel_q, sel_d;
  logic [1:0]          len_q, len_d;
  logic [RESP_W-1:0]   resp_shifted;

  // New bits enter at the LSB so the first sampled bit ends up in the MSB.
  assign resp_shifted = (resp_sr_q << 1) | RESP_W'(so);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    chal_sr_d   = chal_sr_q;
    resp_sr_d   = resp_sr_q;
    resp_d      = resp_q;
    valid_d     = valid_q;
    si_d        = si_q;
    puf_reset_d = puf_reset_q;
    sel_d       = sel_q;
    len_d       = len_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // The MSB goes straight to si so it is visible in the first LOAD cycle.
          si_d      = chal[CHAL_W-1];
          chal_sr_d = chal << 1;
          sel_d     = sel_in;
          len_d     = len_in;
          cnt_d     = CNT_W'(CHAL_W - 1);
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (cnt_q == '0) begin
          si_d        = 1'b0;
          puf_reset_d = 1'b1;
          cnt_d       = CNT_W'(EVAL_CYCLES - 1);
          state_d     = EVAL;
        end else begin
          si_d      = chal_sr_q[CHAL_W-1];
          chal_sr_d = chal_sr_q << 1;
          cnt_d     = cnt_q - CNT_W'(1);
        end
      end
      EVAL: begin
        if (cnt_q == '0) begin
          puf_reset_d = 1'b0;
          resp_sr_d   = '0;
          cnt_d       = CNT_W'(RESP_W - 1);
          state_d     = CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      CAPTURE: begin
        resp_sr_d = resp_shifted;
        if (cnt_q == '0) begin
          resp_d  = resp_shifted;
          valid_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (resp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      chal_sr_q   <= '0;
      resp_sr_q   <= '0;
      resp_q      <= '0;
      valid_q     <= 1'b0;
      si_q        <= 1'b0;
      puf_reset_q <= 1'b0;
      sel_q       <= 2'b00;
      len_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      chal_sr_q   <= chal_sr_d;
      resp_sr_q   <= resp_sr_d;
      resp_q      <= resp_d;
      valid_q     <= valid_d;
      si_q        <= si_d;
      puf_reset_q <= puf_reset_d;
      sel_q       <= sel_d;
      len_q       <= len_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign resp       = resp_q;
  assign resp_valid = valid_q;
  assign si         = si_q;
  assign puf_reset  = puf_reset_q;
  assign puf_sel    = sel_q;
  assign length     = len_q;

endmodule

// File: tb/tb_puf_scan_master.sv
// Directed self-checking bench for puf_scan_master with default parameters.
module tb_puf_scan_master;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [15:0] chal;
  logic [1:0]  sel_in;
  logic [1:0]  len_in;
  logic        busy;
  logic [15:0] resp;
  logic        resp_valid;
  logic        resp_ready;
  logic        si;
  logic        so;
  logic        puf_reset;
  logic [1:0]  puf_sel;
  logic [1:0]  length;

  int compared   = 0;
  int mismatched = 0;

  puf_scan_master #(
    .CHAL_W(16),
    .RESP_W(16),
    .EVAL_CYCLES(8)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .start(start),
    .chal(chal),
    .sel_in(sel_in),
    .len_in(len_in),
    .busy(busy),
    .resp(resp),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .si(si),
    .so(so),
    .puf_reset(puf_reset),
    .puf_sel(puf_sel),
    .length(length)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rstn       = 1'b0;
    start      = 1'b0;
    chal       = 16'h0000;
    sel_in     = 2'b00;
    len_in     = 2'b00;
    resp_ready = 1'b0;
    so         = 1'b0;
    repeat (3) nextCycle();
    rstn = 1'b1;
    repeat (10) nextCycle();
    @(negedge clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    compared++; if (si !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_si: got %b expected 0", si); end
    compared++; if (puf_reset !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_puf_reset: got %b expected 0", puf_reset); end
    compared++; if (resp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    compared++; if (resp !== 16'h0000) begin mismatched++; $display("[TB] FAIL reset_resp: got %h expected 0000", resp); end
    compared++; if ({puf_sel, length} !== 4'b0000) begin mismatched++; $display("[TB] FAIL reset_cfg: got %b expected 0000", {puf_sel, length}); end
    nextCycle();
  endtask

  task automatic test_shift_and_capture;
    logic [15:0] chalV;
    logic [15:0] soWord;
    chalV  = 16'hA5C3;
    soWord = 16'hBEEF;
    chal   = chalV;
    sel_in = 2'd2;
    len_in = 2'd3;
    start  = 1'b1;
    nextCycle();
    start  = 1'b0;
    sel_in = 2'd0;
    len_in = 2'd0;
    chal   = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      compared++; if (si !== chalV[15-k]) begin mismatched++; $display("[TB] FAIL load_si[%0d]: got %b expected %b", k, si, chalV[15-k]); end
      compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL load_busy[%0d]: got %b expected 1", k, busy); end
      compared++; if (puf_reset !== 1'b0) begin mismatched++; $display("[TB] FAIL load_puf_reset[%0d]: got %b expected 0", k, puf_reset); end
      compared++; if ({puf_sel, length} !== {2'd2, 2'd3}) begin mismatched++; $display("[TB] FAIL load_cfg[%0d]: got %b expected 1011", k, {puf_sel, length}); end
      nextCycle();
    end
    for (int n = 16; n < 24; n++) begin
      @(negedge clk);
      compared++; if (puf_reset !== 1'b1) begin mismatched++; $display("[TB] FAIL eval_puf_reset[%0d]: got %b expected 1", n, puf_reset); end
      compared++; if (si !== 1'b0) begin mismatched++; $display("[TB] FAIL eval_si[%0d]: got %b expected 0", n, si); end
      nextCycle();
    end
    for (int i = 0; i < 16; i++) begin
      so = soWord[15-i];
      @(negedge clk);
      compared++; if (puf_reset !== 1'b0) begin mismatched++; $display("[TB] FAIL cap_puf_reset[%0d]: got %b expected 0", i, puf_reset); end
      compared++; if (resp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL cap_early_valid[%0d]: got %b expected 0", i, resp_valid); end
      compared++; if ({puf_sel, length} !== {2'd2, 2'd3}) begin mismatched++; $display("[TB] FAIL cap_cfg[%0d]: got %b expected 1011", i, {puf_sel, length}); end
      nextCycle();
    end
    so = 1'b0;
    @(negedge clk);
    compared++; if (resp_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL valid_at_40: got %b expected 1", resp_valid); end
    compared++; if (resp !== 16'hBEEF) begin mismatched++; $display("[TB] FAIL resp_beef: got %h expected beef", resp); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL done_busy: got %b expected 1", busy); end
    compared++; if ({puf_sel, length} !== {2'd2, 2'd3}) begin mismatched++; $display("[TB] FAIL done_cfg: got %b expected 1011", {puf_sel, length}); end
    nextCycle();
  endtask

  task automatic test_backpressure;
    for (int n = 0; n < 20; n++) begin
      start = (n == 5);
      chal  = (n == 5) ? 16'h0F0F : 16'h0000;
      @(negedge clk);
      compared++; if (resp_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_valid[%0d]: got %b expected 1", n, resp_valid); end
      compared++; if (resp !== 16'hBEEF) begin mismatched++; $display("[TB] FAIL bp_resp[%0d]: got %h expected beef", n, resp); end
      compared++; if (si !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_si[%0d]: got %b expected 0", n, si); end
      compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_busy[%0d]: got %b expected 1", n, busy); end
      nextCycle();
    end
    // A start coincident with the handshake must not be accepted.
    resp_ready = 1'b1;
    start      = 1'b1;
    chal       = 16'hFFFF;
    nextCycle();
    resp_ready = 1'b0;
    start      = 1'b0;
    chal       = 16'h0000;
    @(negedge clk);
    compared++; if (resp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL hs_valid: got %b expected 0", resp_valid); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL hs_busy: got %b expected 0", busy); end
    compared++; if (resp !== 16'hBEEF) begin mismatched++; $display("[TB] FAIL hs_resp_kept: got %h expected beef", resp); end
    nextCycle();
    @(negedge clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL hs_start_ignored: got %b expected 0", busy); end
    nextCycle();
  endtask

  task automatic test_start_while_busy;
    logic [15:0] chalV;
    int          rises;
    logic        prevValid;
    chalV     = 16'h0001;
    rises     = 0;
    prevValid = 1'b0;
    chal      = chalV;
    sel_in    = 2'd1;
    len_in    = 2'd1;
    start     = 1'b1;
    so        = 1'b0;
    nextCycle();
    start = 1'b0;
    for (int n = 0; n < 62; n++) begin
      if (n == 5) begin
        start  = 1'b1;
        chal   = 16'hFFFF;
        sel_in = 2'd3;
        len_in = 2'd0;
      end
      if (n == 6) start = 1'b0;
      resp_ready = (n == 45);
      @(negedge clk);
      if (n < 16) begin
        compared++; if (si !== chalV[15-n]) begin mismatched++; $display("[TB] FAIL busy_si[%0d]: got %b expected %b", n, si, chalV[15-n]); end
      end
      if (n == 40) begin
        compared++; if (resp !== 16'h0000) begin mismatched++; $display("[TB] FAIL busy_resp: got %h expected 0000", resp); end
        compared++; if ({puf_sel, length} !== {2'd1, 2'd1}) begin mismatched++; $display("[TB] FAIL busy_cfg: got %b expected 0101", {puf_sel, length}); end
      end
      if (resp_valid && !prevValid) rises++;
      prevValid = resp_valid;
      nextCycle();
    end
    resp_ready = 1'b0;
    compared++; if (rises !== 1) begin mismatched++; $display("[TB] FAIL busy_valid_count: got %0d expected 1", rises); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL busy_final_idle: got %b expected 0", busy); end
  endtask

  task automatic test_mid_reset;
    chal   = 16'h5555;
    sel_in = 2'd1;
    len_in = 2'd2;
    start  = 1'b1;
    nextCycle();
    start = 1'b0;
    repeat (18) nextCycle();
    @(negedge clk);
    compared++; if (puf_reset !== 1'b1) begin mismatched++; $display("[TB] FAIL mr_in_eval: got %b expected 1", puf_reset); end
    #2;
    rstn = 1'b0;
    #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL mr_busy: got %b expected 0", busy); end
    compared++; if (puf_reset !== 1'b0) begin mismatched++; $display("[TB] FAIL mr_puf_reset: got %b expected 0", puf_reset); end
    compared++; if ({puf_sel, length} !== 4'b0000) begin mismatched++; $display("[TB] FAIL mr_cfg: got %b expected 0000", {puf_sel, length}); end
    compared++; if ({resp_valid, si} !== 2'b00) begin mismatched++; $display("[TB] FAIL mr_valid_si: got %b expected 00", {resp_valid, si}); end
    repeat (3) nextCycle();
    rstn = 1'b1;
    nextCycle();
    chal   = 16'h1234;
    sel_in = 2'd3;
    len_in = 2'd1;
    so     = 1'b1;
    start  = 1'b1;
    nextCycle();
    start = 1'b0;
    repeat (39) nextCycle();
    @(negedge clk);
    compared++; if (resp_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL mr_valid_39: got %b expected 0", resp_valid); end
    nextCycle();
    @(negedge clk);
    compared++; if (resp_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL mr_valid_40: got %b expected 1", resp_valid); end
    compared++; if (resp !== 16'hFFFF) begin mismatched++; $display("[TB] FAIL mr_resp: got %h expected ffff", resp); end
    nextCycle();
    resp_ready = 1'b1;
    nextCycle();
    resp_ready = 1'b0;
    so         = 1'b0;
    @(negedge clk);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL mr_final_idle: got %b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_shift_and_capture();
    test_backpressure();
    test_start_while_busy();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
